// File: rtl/soc_pkg.sv
// Shared memory-map constants and request/response types for the SoC memory responders.
package soc_pkg;

    localparam logic [31:0] BOOT_ROM_BASE  = 32'h0000_0000;
    localparam int unsigned BOOT_ROM_WORDS = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } rom_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rom_rsp_t;

    // The range check uses the full 32-bit offset so that addresses past the
    // ROM cannot alias back onto it once truncated to the word address.
    function automatic logic rom_req_err(input rom_req_t    req,
                                         input logic [31:0] base,
                                         input int unsigned depth);
        logic [31:0] off;
        off = req.addr - base;
        return req.we
            || (req.addr[1:0] != 2'b00)
            || (req.addr < base)
            || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/boot_rom_reader.sv
// Valid/ready read responder for the single-port boot pROM: request decode, S1 ROM
// access stage and an output response register, with full backpressure.
module boot_rom_reader
    import soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BOOT_ROM_BASE,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH_WORDS = BOOT_ROM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [31:0]       rom_dout
);

    rom_req_t    req;
    rom_rsp_t    out_q;
    logic [31:0] off;
    logic        err;
    logic        out_free;
    logic        s1_adv;
    logic        fire;
    logic        s1_valid;
    logic        s1_err;

    always_comb begin
        req      = '{addr: req_addr, we: req_we};
        off      = req_addr - BASE_ADDR;
        err      = rom_req_err(req, BASE_ADDR, DEPTH_WORDS);
        out_free = !rsp_valid || rsp_ready;
        s1_adv   = s1_valid && out_free;
        req_ready = !s1_valid || s1_adv;
        fire     = req_valid && req_ready;
    end

    // ROM pins are forced idle while in reset so no access is launched then.
    assign rom_ce    = rst_n && fire && !err;
    assign rom_oce   = rom_ce;
    assign rom_ad    = rst_n ? ADDR_W'(off >> 2) : '0;
    assign rom_reset = !rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else if (fire) begin
            s1_valid <= 1'b1;
            s1_err   <= err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // A new ROM read only launches when S1 drains on the same edge, so rom_dout
    // still holds S1's word whenever S1 is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            out_q     <= '0;
        end else if (s1_adv) begin
            rsp_valid  <= 1'b1;
            out_q.err  <= s1_err;
            out_q.data <= s1_err ? '0 : rom_dout;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_data = out_q.data;
    assign rsp_err  = out_q.err;

endmodule

// File: tb/tb_boot_rom_reader.sv
// Scoreboard bench for boot_rom_reader with a behavioural bypass-mode pROM model.
module tb_boot_rom_reader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [9:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [31:0] rom_dout;

    boot_rom_reader #(
        .BASE_ADDR  (BASE),
        .ADDR_W     (10),
        .DEPTH_WORDS(WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_we   (req_we),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .rom_ad   (rom_ad),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_reset(rom_reset),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = (i * 32'h9E37_79B9) ^ 32'h1234_5678;
        mem[0] = 32'hD000_1117;
        mem[1] = 32'h0001_0113;
    end

    always @(posedge clk) begin
        if (rom_reset)   rom_dout <= '0;
        else if (rom_ce) rom_dout <= mem[rom_ad];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          lat;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned fired = 0;
    int unsigned delivered = 0;
    bit          rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic w);
        return w || (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= WORDS);
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [31:0] a, input logic w, input bit lat);
        exp_t e;
        logic er;
        er = ref_err(a, w);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        for (int c = 0; c < 200; c++) begin
            #4;
            check("rom_ce", {31'd0, rom_ce}, {31'd0, req_ready && !er});
            check("rom_oce", {31'd0, rom_oce}, {31'd0, rom_ce});
            if (req_ready && !er) check("rom_ad", {22'd0, rom_ad}, (a - BASE) / 4);
            if (req_ready) begin
                e.err  = er;
                e.data = er ? 32'h0 : mem[(a - BASE) / 4];
                e.lat  = lat;
                e.cyc  = cyc;
                sb.push_back(e);
                fired++;
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            #4;
            check("rom_ce_idle", {31'd0, rom_ce}, 32'd0);
            @(negedge clk);
        end
    endtask

    // Monitor: samples 2 time units before each rising edge.
    initial begin
        exp_t        e;
        bit          held = 0;
        logic [31:0] held_data;
        logic        held_err;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n !== 1'b1) begin
                held = 0;
                continue;
            end
            check("req_ready_model", {31'd0, req_ready}, {31'd0, (sb.size() < 2) || rsp_ready});
            if (rsp_valid) begin
                if (held) begin
                    check("rsp_data_stable", rsp_data, held_data);
                    check("rsp_err_stable", {31'd0, rsp_err}, {31'd0, held_err});
                end
                if (sb.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    if (!held && e.lat) check("latency", cyc - e.cyc, 32'd2);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        delivered++;
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        held = 0;
                    end else begin
                        held      = 1;
                        held_data = rsp_data;
                        held_err  = rsp_err;
                    end
                end
            end else begin
                if (held) check("rsp_dropped", 32'd0, 32'd1);
                held = 0;
            end
        end
    end

    always @(negedge clk) if (rand_ready) rsp_ready = ($urandom % 3) != 0;

    initial begin
        logic [31:0] a;
        logic        w;
        int unsigned k;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
        check("rst_rom_ad", {22'd0, rom_ad}, 32'd0);
        check("rst_rom_reset", {31'd0, rom_reset}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rom_reset_released", {31'd0, rom_reset}, 32'd0);
        @(negedge clk);

        send(32'h0, 1'b0, 1'b1);
        idle(3);

        send(32'h0, 1'b0, 1'b1);
        send(32'h4, 1'b0, 1'b1);
        send(32'h8, 1'b0, 1'b1);
        idle(3);

        rsp_ready = 1'b0;
        send(32'h0, 1'b0, 1'b0);
        send(32'h4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #4;
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_rom_ce", {31'd0, rom_ce}, 32'd0);
            check("stall_rsp_data", rsp_data, 32'hD000_1117);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        idle(3);

        send(32'h2, 1'b0, 1'b1);
        idle(2);
        send(32'h1000, 1'b0, 1'b1);
        idle(2);
        send(32'h0, 1'b1, 1'b1);
        idle(3);

        rsp_ready = 1'b0;
        send(32'h8, 1'b0, 1'b0);
        send(32'hC, 1'b0, 1'b0);
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_rom_reset", {31'd0, rom_reset}, 32'd1);
        sb.delete();
        fired = delivered;
        @(negedge clk);
        check("arst_rom_reset_hold", {31'd0, rom_reset}, 32'd1);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1 check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        send(32'h4, 1'b0, 1'b1);
        idle(3);

        rand_ready = 1;
        k = 0;
        while (k < 1000) begin
            case ($urandom % 12)
                0:       begin a = ($urandom % WORDS) * 4 + 1 + ($urandom % 3); w = 1'b0; end
                1:       begin a = 32'h1000 + ($urandom % 32'h10000) * 4; w = 1'b0; end
                2:       begin a = ($urandom % WORDS) * 4; w = 1'b1; end
                default: begin a = ($urandom % WORDS) * 4; w = 1'b0; k++; end
            endcase
            send(a, w, 1'b0);
            if (($urandom % 4) == 0) idle($urandom_range(1, 2));
        end
        rand_ready = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb.size(), 32'd0);
        check("delivered_count", delivered, fired);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
